// File: rtl/imp_chk_pkg.sv
// ==================================================================
// imp_chk_pkg : shared types and helpers for imp_window_chk   rev 1.0
// ==================================================================
`default_nettype none

package imp_chk_pkg;

  localparam int FAIL_CH_W = 8;

  typedef struct packed {
    logic                 vld;
    logic [FAIL_CH_W-1:0] ch;
  } fail_rpt_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/imp_chk_lane.sv
// ==================================================================
// imp_chk_lane : one channel of a |-> ##[MIN_DLY:MAX_DLY] b   rev 1.0
// ==================================================================
`default_nettype none

module imp_chk_lane #(
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic launch,
  input  logic cons,
  output logic fail,
  output logic pending
);

  // Bit k is an obligation that is k cycles old in the current cycle.
  logic [MAX_DLY:0] w_cur;

  generate
    if (MAX_DLY > 0) begin : g_age
      logic [MAX_DLY-1:0] r_pend;
      logic [MAX_DLY-1:0] w_disc;

      for (genvar k = 0; k < MAX_DLY; k++) begin : g_disc
        if (k >= MIN_DLY) begin : g_win
          assign w_disc[k] = w_cur[k] & cons;
        end else begin : g_early
          assign w_disc[k] = 1'b0;
        end
      end

      assign w_cur = {r_pend, launch};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pend <= '0;
        end else if (clr) begin
          r_pend <= '0;
        end else begin
          r_pend <= w_cur[MAX_DLY-1:0] & ~w_disc;
        end
      end

      assign pending = |r_pend;
    end else begin : g_noage
      assign w_cur   = launch;
      assign pending = 1'b0;
    end
  endgenerate

  // Combinational here; the top registers it together with the counters.
  assign fail = w_cur[MAX_DLY] & ~cons;

endmodule

`default_nettype wire

// File: rtl/imp_window_chk.sv
// ==================================================================
// imp_window_chk : NCH-channel windowed implication checker   rev 1.0
// ==================================================================
`default_nettype none

module imp_window_chk
  import imp_chk_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NCH-1:0]          ant,
  input  logic [NCH-1:0]          cons,
  output logic [NCH-1:0]          fail_pulse,
  output logic [NCH-1:0]          fail_sticky,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic                    first_fail_vld,
  output logic [ch_w(NCH)-1:0]    first_fail_ch,
  output logic                    busy
);

  localparam int CH_W = ch_w(NCH);
  localparam logic [31:0] c_cnt_max = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : 32'((64'd1 << CNT_W) - 64'd1);

  generate
    if (MIN_DLY < 0 || MAX_DLY < MIN_DLY) begin : g_bad_window
      $error("imp_window_chk: need 0 <= MIN_DLY <= MAX_DLY");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
      $error("imp_window_chk: CNT_W must be in 1..32");
    end
    if (NCH < 1 || NCH > (1 << FAIL_CH_W)) begin : g_bad_nch
      $error("imp_window_chk: NCH out of range");
    end
  endgenerate

  logic [NCH-1:0]   w_fail;
  logic [NCH-1:0]   w_pend;
  logic [31:0]      w_pop;
  logic [31:0]      w_cnt_nxt;
  fail_rpt_t        w_rpt;

  logic [NCH-1:0]   r_pulse;
  logic [NCH-1:0]   r_sticky;
  logic [CNT_W-1:0] r_cnt;
  fail_rpt_t        r_first;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_lane
      imp_chk_lane #(
        .MIN_DLY (MIN_DLY),
        .MAX_DLY (MAX_DLY)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .launch  (ant[i] & en),
        .cons    (cons[i]),
        .fail    (w_fail[i]),
        .pending (w_pend[i])
      );
    end
  endgenerate

  // Descending scan so the lowest failing index is the one left in w_rpt.ch.
  always_comb begin
    w_pop = '0;
    w_rpt = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_fail[i]) begin
        w_pop    = w_pop + 32'd1;
        w_rpt.ch = FAIL_CH_W'(i);
      end
    end
    w_rpt.vld = |w_fail;
    w_cnt_nxt = sat_add(32'(r_cnt), w_pop, c_cnt_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse  <= '0;
      r_sticky <= '0;
      r_cnt    <= '0;
      r_first  <= '0;
    end else if (clr) begin
      r_pulse  <= '0;
      r_sticky <= '0;
      r_cnt    <= '0;
      r_first  <= '0;
    end else begin
      r_pulse  <= w_fail;
      r_sticky <= r_sticky | w_fail;
      r_cnt    <= CNT_W'(w_cnt_nxt);
      if (!r_first.vld && w_rpt.vld) begin
        r_first <= w_rpt;
      end
    end
  end

  assign fail_pulse     = r_pulse;
  assign fail_sticky    = r_sticky;
  assign fail_cnt       = r_cnt;
  assign first_fail_vld = r_first.vld;
  assign first_fail_ch  = CH_W'(r_first.ch);
  assign busy           = |w_pend;

endmodule

`default_nettype wire
